uart_tx_feeder: RTL and testbench

Byte buffer and sequencer upstream of uart_master. It accepts bytes from the main bus into a synchronous FIFO, presents them one at a time on uart_master's data/en_tx inputs, and watches u_tx_done before advancing. This lets the bus push bursts without tracking the serial timing of each frame.

---
 rtl/uart_pkg.sv | 13 +
 rtl/uart_tx_feeder_if.sv | 32 +++
 rtl/uart_sync_fifo.sv | 67 ++++++
 rtl/uart_tx_feeder.sv | 81 ++++++++
 tb/tb_uart_tx_feeder.sv | 325 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared UART buffering definitions: default widths/depths and the TX feeder state type.
package uart_pkg;

   localparam int unsigned UART_DATA_WIDTH = 8;
   localparam int unsigned UART_FIFO_DEPTH = 16;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SEND = 2'd1,
      GAP  = 2'd2
   } tx_feed_state_t;

endpackage

// File: rtl/uart_tx_feeder_if.sv
// Bus-write and uart_master-facing signals of the TX feeder.
interface uart_tx_feeder_if
   import uart_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = UART_DATA_WIDTH,
   parameter int unsigned DEPTH      = UART_FIFO_DEPTH
);

   localparam int unsigned CNT_WIDTH = $clog2(DEPTH) + 1;

   logic                  wr_en;
   logic [DATA_WIDTH-1:0] wr_data;
   logic                  full;
   logic                  empty;
   logic [CNT_WIDTH-1:0]  count;
   logic                  overflow;
   logic [DATA_WIDTH-1:0] tx_data;
   logic                  tx_en;
   logic                  tx_done;
   logic                  busy;

   modport slave (
      input  wr_en, wr_data, tx_done,
      output full, empty, count, overflow, tx_data, tx_en, busy
   );

   modport master (
      output wr_en, wr_data, tx_done,
      input  full, empty, count, overflow, tx_data, tx_en, busy
   );

endinterface

// File: rtl/uart_sync_fifo.sv
// Single-clock circular FIFO with registered occupancy count and a dropped-write pulse.
module uart_sync_fifo
   import uart_pkg::*;
#(
   parameter int unsigned  DATA_WIDTH = UART_DATA_WIDTH,
   parameter int unsigned  DEPTH      = UART_FIFO_DEPTH,
   localparam int unsigned CNT_WIDTH  = $clog2(DEPTH) + 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  wr_en,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic                  rd_en,
   output logic [DATA_WIDTH-1:0] rd_data,
   output logic                  full,
   output logic                  empty,
   output logic [CNT_WIDTH-1:0]  count,
   output logic                  overflow
);

   localparam int unsigned          PTR_WIDTH = $clog2(DEPTH);
   localparam logic [PTR_WIDTH-1:0] PTR_ONE   = PTR_WIDTH'(1);
   localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);
   localparam logic [CNT_WIDTH-1:0] CNT_FULL  = CNT_WIDTH'(DEPTH);

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [PTR_WIDTH-1:0]  wr_ptr_q, rd_ptr_q;
   logic [CNT_WIDTH-1:0]  count_q;
   logic                  overflow_q;
   logic                  do_wr, do_rd;

   assign full  = (count_q == CNT_FULL);
   assign empty = (count_q == '0);

   // full is the pre-pop value, so a write in a full cycle is dropped even if a pop also occurs
   assign do_wr = wr_en & ~full;
   assign do_rd = rd_en & ~empty;

   always_ff @(posedge clk) begin
      if (do_wr) begin
         mem[wr_ptr_q] <= wr_data;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         overflow_q <= wr_en & full;
         if (do_wr) wr_ptr_q <= wr_ptr_q + PTR_ONE;
         if (do_rd) rd_ptr_q <= rd_ptr_q + PTR_ONE;
         unique case ({do_wr, do_rd})
            2'b10:   count_q <= count_q + CNT_ONE;
            2'b01:   count_q <= count_q - CNT_ONE;
            default: count_q <= count_q;
         endcase
      end
   end

   assign rd_data  = mem[rd_ptr_q];
   assign count    = count_q;
   assign overflow = overflow_q;

endmodule

// File: rtl/uart_tx_feeder.sv
// Buffers bus bytes and hands them to uart_master one frame at a time, popping once per tx_done.
module uart_tx_feeder
   import uart_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = UART_DATA_WIDTH,
   parameter int unsigned DEPTH      = UART_FIFO_DEPTH
) (
   input logic             clk,
   input logic             rst,
   uart_tx_feeder_if.slave bus
);

   tx_feed_state_t        state_q, state_d;
   logic [DATA_WIDTH-1:0] tx_data_q, tx_data_d;
   logic                  tx_en_q, tx_en_d;
   logic [DATA_WIDTH-1:0] fifo_rd_data;
   logic                  fifo_empty;
   logic                  pop;

   uart_sync_fifo #(
      .DATA_WIDTH(DATA_WIDTH),
      .DEPTH     (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (bus.wr_en),
      .wr_data (bus.wr_data),
      .rd_en   (pop),
      .rd_data (fifo_rd_data),
      .full    (bus.full),
      .empty   (fifo_empty),
      .count   (bus.count),
      .overflow(bus.overflow)
   );

   always_comb begin
      state_d   = state_q;
      tx_data_d = tx_data_q;
      tx_en_d   = tx_en_q;
      pop       = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (!fifo_empty) begin
               tx_data_d = fifo_rd_data;
               tx_en_d   = 1'b1;
               state_d   = SEND;
            end
         end
         SEND: begin
            if (bus.tx_done) begin
               tx_en_d = 1'b0;
               pop     = 1'b1;
               state_d = GAP;
            end
         end
         // Wait for the master to release done so a long done level pops only once
         GAP: begin
            if (!bus.tx_done) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         tx_data_q <= '0;
         tx_en_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         tx_data_q <= tx_data_d;
         tx_en_q   <= tx_en_d;
      end
   end

   assign bus.empty   = fifo_empty;
   assign bus.tx_data = tx_data_q;
   assign bus.tx_en   = tx_en_q;
   assign bus.busy    = (state_q != IDLE);

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Self-checking bench for uart_tx_feeder: vector table, directed corner cases, randomized run.
module tb_uart_tx_feeder;
   import uart_pkg::*;

   localparam int unsigned DW    = 8;
   localparam int unsigned DEPTH = 16;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   uart_tx_feeder_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) bus ();

   uart_tx_feeder #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
      end
   endtask

   // Reference model: the FIFO is a plain queue; a master that answers each frame
   bit         auto_on;
   logic [7:0] m_q[$];
   logic [7:0] got[$];
   bit         pop_pend, prev_en, frame, done_hi;
   int         delay, hold;

   task automatic model_step();
      bit acc, ovf_exp;
      ovf_exp = bus.wr_en && (m_q.size() == DEPTH);
      acc     = bus.wr_en && (m_q.size() < DEPTH);
      if (pop_pend) begin
         if (m_q.size() > 0) void'(m_q.pop_front());
         pop_pend = 1'b0;
      end
      if (acc) m_q.push_back(bus.wr_data);
      chk("model.count", 32'(bus.count), 32'(m_q.size()));
      chk("model.overflow", 32'(bus.overflow), 32'(ovf_exp));
      chk("model.full", 32'(bus.full), 32'(m_q.size() == DEPTH));
      chk("model.empty", 32'(bus.empty), 32'(m_q.size() == 0));
      if (bus.tx_en && !prev_en) begin
         if (m_q.size() == 0) chk("model.tx_unexpected", 32'(bus.tx_data), 32'hFFFF_FFFF);
         else chk("model.tx_order", 32'(bus.tx_data), 32'(m_q[0]));
         got.push_back(bus.tx_data);
         frame = 1'b1;
         delay = int'($urandom_range(0, 4));
      end
      prev_en = bus.tx_en;
      if (done_hi) begin
         hold--;
         if (hold == 0) begin
            bus.tx_done = 1'b0;
            done_hi     = 1'b0;
            frame       = 1'b0;
         end
      end else if (frame) begin
         if (delay == 0) begin
            bus.tx_done = 1'b1;
            done_hi     = 1'b1;
            pop_pend    = 1'b1;
            hold        = int'($urandom_range(1, 5));
         end else begin
            delay--;
         end
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      #1;
      if (auto_on) model_step();
   endtask

   task automatic model_reset();
      m_q.delete();
      got.delete();
      pop_pend = 1'b0;
      prev_en  = 1'b0;
      frame    = 1'b0;
      done_hi  = 1'b0;
   endtask

   task automatic write(input logic [7:0] d);
      bus.wr_en   = 1'b1;
      bus.wr_data = d;
      cycle();
      bus.wr_en   = 1'b0;
   endtask

   task automatic drain(input logic [7:0] exp_q[$], input string tag);
      int n;
      foreach (exp_q[i]) begin
         n = 0;
         while (!bus.tx_en && n < 50) begin
            cycle();
            n++;
         end
         if (n >= 50) chk($sformatf("%s.timeout%0d", tag, i), 32'(bus.tx_en), 32'd1);
         chk($sformatf("%s.data%0d", tag, i), 32'(bus.tx_data), 32'(exp_q[i]));
         bus.tx_done = 1'b1;
         cycle();
         bus.tx_done = 1'b0;
         cycle();
      end
      repeat (6) cycle();
      chk({tag, ".empty"}, 32'(bus.empty), 32'd1);
      chk({tag, ".no_extra_tx"}, 32'(bus.tx_en), 32'd0);
   endtask

   typedef struct {
      logic       wr_en;
      logic [7:0] wr_data;
      logic       tx_done;
      logic [4:0] count;
      logic       empty;
      logic       full;
      logic       tx_en;
      logic       busy;
      logic [7:0] tx_data;
   } vec_t;

   vec_t tbl[13];

   initial begin
      logic [7:0] e[$];
      int         n;
      int         bad_hold;

      //           wr  data   done  cnt  emp full en  busy data
      tbl[0]  = '{1'b1, 8'h95, 1'b0, 5'd1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
      tbl[1]  = '{1'b0, 8'h00, 1'b0, 5'd1, 1'b0, 1'b0, 1'b1, 1'b1, 8'h95};
      tbl[2]  = '{1'b0, 8'h00, 1'b0, 5'd1, 1'b0, 1'b0, 1'b1, 1'b1, 8'h95};
      tbl[3]  = '{1'b0, 8'h00, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h95};
      tbl[4]  = '{1'b0, 8'h00, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h95};
      tbl[5]  = '{1'b0, 8'h00, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h95};
      tbl[6]  = '{1'b1, 8'h3C, 1'b0, 5'd1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h95};
      tbl[7]  = '{1'b1, 8'h5A, 1'b0, 5'd2, 1'b0, 1'b0, 1'b1, 1'b1, 8'h3C};
      tbl[8]  = '{1'b0, 8'h00, 1'b1, 5'd1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h3C};
      tbl[9]  = '{1'b0, 8'h00, 1'b0, 5'd1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h3C};
      tbl[10] = '{1'b0, 8'h00, 1'b0, 5'd1, 1'b0, 1'b0, 1'b1, 1'b1, 8'h5A};
      tbl[11] = '{1'b0, 8'h00, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h5A};
      tbl[12] = '{1'b0, 8'h00, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h5A};

      auto_on     = 1'b0;
      model_reset();
      rst         = 1'b1;
      bus.wr_en   = 1'b0;
      bus.wr_data = '0;
      bus.tx_done = 1'b0;
      #2;
      chk("reset.tx_en", 32'(bus.tx_en), 32'd0);
      chk("reset.tx_data", 32'(bus.tx_data), 32'd0);
      chk("reset.overflow", 32'(bus.overflow), 32'd0);
      chk("reset.count", 32'(bus.count), 32'd0);
      chk("reset.empty", 32'(bus.empty), 32'd1);
      chk("reset.full", 32'(bus.full), 32'd0);
      chk("reset.busy", 32'(bus.busy), 32'd0);
      cycle();
      rst = 1'b0;

      // Vector table: single frames with short done, write during IDLE/SEND
      for (int i = 0; i < 13; i++) begin
         bus.wr_en   = tbl[i].wr_en;
         bus.wr_data = tbl[i].wr_data;
         bus.tx_done = tbl[i].tx_done;
         cycle();
         chk($sformatf("vec%0d.count", i), 32'(bus.count), 32'(tbl[i].count));
         chk($sformatf("vec%0d.empty", i), 32'(bus.empty), 32'(tbl[i].empty));
         chk($sformatf("vec%0d.full", i), 32'(bus.full), 32'(tbl[i].full));
         chk($sformatf("vec%0d.tx_en", i), 32'(bus.tx_en), 32'(tbl[i].tx_en));
         chk($sformatf("vec%0d.busy", i), 32'(bus.busy), 32'(tbl[i].busy));
         chk($sformatf("vec%0d.tx_data", i), 32'(bus.tx_data), 32'(tbl[i].tx_data));
      end
      bus.wr_en   = 1'b0;
      bus.tx_done = 1'b0;
      cycle();

      // Single byte, master answers 20 cycles after tx_en
      write(8'h95);
      n = 0;
      while (!bus.tx_en && n < 10) begin
         cycle();
         n++;
      end
      chk("single.latency", 32'(n), 32'd1);
      bad_hold = 0;
      repeat (19) begin
         cycle();
         if (!(bus.tx_en && bus.tx_data == 8'h95)) bad_hold++;
      end
      chk("single.stable", 32'(bad_hold), 32'd0);
      chk("single.count_before", 32'(bus.count), 32'd1);
      bus.tx_done = 1'b1;
      cycle();
      chk("single.tx_en_low", 32'(bus.tx_en), 32'd0);
      chk("single.count_after", 32'(bus.count), 32'd0);
      bus.tx_done = 1'b0;
      cycle();
      chk("single.busy_low", 32'(bus.busy), 32'd0);

      // Burst to full, one overflow, 0xAA never sent
      for (int i = 0; i < 16; i++) write(8'(i));
      chk("burst.count", 32'(bus.count), 32'd16);
      chk("burst.full", 32'(bus.full), 32'd1);
      write(8'hAA);
      chk("burst.ovf_pulse", 32'(bus.overflow), 32'd1);
      chk("burst.count_hold", 32'(bus.count), 32'd16);
      cycle();
      chk("burst.ovf_clear", 32'(bus.overflow), 32'd0);
      e.delete();
      for (int i = 0; i < 16; i++) e.push_back(8'(i));
      drain(e, "burst");

      // Write and pop in the same cycle, FIFO full: write dropped
      for (int i = 0; i < 16; i++) write(8'(8'h30 + i));
      bus.wr_en   = 1'b1;
      bus.wr_data = 8'h55;
      bus.tx_done = 1'b1;
      cycle();
      chk("simfull.overflow", 32'(bus.overflow), 32'd1);
      chk("simfull.count", 32'(bus.count), 32'd15);
      bus.wr_en   = 1'b0;
      bus.tx_done = 1'b0;
      cycle();
      e.delete();
      for (int i = 1; i < 16; i++) e.push_back(8'(8'h30 + i));
      drain(e, "simfull");

      // Write and pop in the same cycle, count 5: count unchanged, byte kept
      for (int i = 0; i < 5; i++) write(8'(8'h40 + i));
      cycle();
      chk("sim5.tx_en", 32'(bus.tx_en), 32'd1);
      bus.wr_en   = 1'b1;
      bus.wr_data = 8'h55;
      bus.tx_done = 1'b1;
      cycle();
      chk("sim5.count", 32'(bus.count), 32'd5);
      chk("sim5.overflow", 32'(bus.overflow), 32'd0);
      bus.wr_en   = 1'b0;
      bus.tx_done = 1'b0;
      cycle();
      e = '{8'h41, 8'h42, 8'h43, 8'h44, 8'h55};
      drain(e, "sim5");

      // tx_done held 10 cycles: one pop, tx_en stays low
      write(8'hA1);
      write(8'hA2);
      cycle();
      chk("long.first", 32'(bus.tx_data), 32'hA1);
      bus.tx_done = 1'b1;
      bad_hold    = 0;
      repeat (10) begin
         cycle();
         if (bus.tx_en || bus.count != 5'd1 || !bus.busy) bad_hold++;
      end
      chk("long.one_pop_in_gap", 32'(bad_hold), 32'd0);
      bus.tx_done = 1'b0;
      e = '{8'hA2};
      drain(e, "long");

      // Asynchronous reset mid-frame
      write(8'hC1);
      write(8'hC2);
      write(8'hC3);
      cycle();
      chk("rstmid.sending", 32'(bus.tx_en), 32'd1);
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("rstmid.tx_en_now", 32'(bus.tx_en), 32'd0);
      chk("rstmid.count_now", 32'(bus.count), 32'd0);
      cycle();
      rst = 1'b0;
      repeat (4) cycle();
      chk("rstmid.count", 32'(bus.count), 32'd0);
      chk("rstmid.empty", 32'(bus.empty), 32'd1);
      chk("rstmid.tx_en", 32'(bus.tx_en), 32'd0);
      chk("rstmid.busy", 32'(bus.busy), 32'd0);

      // Wrap-around: 24 bytes through a 16-deep FIFO with a live master
      model_reset();
      auto_on = 1'b1;
      for (int i = 0; i < 24; i++) begin
         write(8'(8'h10 + i));
         repeat (3) cycle();
      end
      n = 0;
      while ((got.size() < 24 || bus.busy || done_hi) && n < 1000) begin
         cycle();
         n++;
      end
      chk("wrap.sent", 32'(got.size()), 32'd24);
      foreach (got[i]) chk($sformatf("wrap.byte%0d", i), 32'(got[i]), 32'(8'h10 + i));

      // Randomized traffic against the queue model
      for (int i = 0; i < 600; i++) begin
         bus.wr_en   = ($urandom_range(0, 2) == 0);
         bus.wr_data = 8'($urandom);
         cycle();
      end
      bus.wr_en = 1'b0;
      n = 0;
      while ((m_q.size() != 0 || bus.busy || done_hi) && n < 3000) begin
         cycle();
         n++;
      end
      chk("rand.drained", 32'(m_q.size()), 32'd0);
      chk("rand.count", 32'(bus.count), 32'd0);
      auto_on = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
